// File: rtl/burst_addr_sequencer_pkg.sv
// Shared definitions for the burst address sequencer and the STP/PTS wrappers.
package burst_addr_sequencer_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_LEN_W  = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/burst_addr_sequencer_shift_reg.sv
// Address register: serial MSB-first load, rotating MSB-first shift-out, increment.
module burst_shift_reg
  import burst_addr_sequencer_pkg::*;
#(
  parameter int unsigned W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic load_ser,
  input  logic shift_en,
  input  logic increment,
  output logic shift_out
);

  logic [W-1:0] sr_q, sr_d;

  // Shifting rotates, so after a full frame the register holds the address again.
  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = {sr_q[W-2:0], load_ser};
    end else if (shift_en) begin
      sr_d = {sr_q[W-2:0], sr_q[W-1]};
    end else if (increment) begin
      sr_d = sr_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign shift_out = sr_q[W-1];

endmodule

// File: rtl/burst_addr_sequencer.sv
// Burst control: captures serial address/length, emits one address frame per beat.
module burst_addr_sequencer
  import burst_addr_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic clk,
  input  logic rst,
  input  logic burst_en,
  input  logic mode_sel,
  input  logic start,
  input  logic burst_len_in,
  input  logic addr_in,
  input  logic beat_done,
  output logic addr_sel,
  output logic addr_ser_out,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(ADDR_W);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             addr_load, addr_rot, addr_inc, addr_msb;
  logic             bit_last;

  assign bit_last = (32'(bit_cnt_q) == ADDR_W - 1);

  // len_q doubles as the remaining-beats counter once LOAD finishes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    addr_load = 1'b0;
    addr_rot  = 1'b0;
    addr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && burst_en) begin
          mode_d    = mode_sel;
          bit_cnt_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_load = 1'b1;
        if (32'(bit_cnt_q) < LEN_W) begin
          len_d = (len_q << 1) | LEN_W'(burst_len_in);
        end
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
          if (!mode_q) begin
            len_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        addr_rot = 1'b1;
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = ST_WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (beat_done) begin
          if (len_q == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_inc = 1'b1;
            len_d    = len_q - LEN_W'(1);
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a coincident beat_done.
    if (!burst_en && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      addr_load = 1'b0;
      addr_rot  = 1'b0;
      addr_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
    end
  end

  burst_shift_reg #(
    .W(ADDR_W)
  ) u_addr_reg (
    .clk       (clk),
    .rst       (rst),
    .load_en   (addr_load),
    .load_ser  (addr_in),
    .shift_en  (addr_rot),
    .increment (addr_inc),
    .shift_out (addr_msb)
  );

  assign addr_sel     = (state_q == ST_SHIFT);
  assign addr_ser_out = addr_sel & addr_msb;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_burst_addr_sequencer.sv
// Scoreboard bench for burst_addr_sequencer: frames and done pulses checked by a monitor.
module tb_burst_addr_sequencer;

  logic clk = 1'b0;
  logic rst, burst_en, mode_sel, start, burst_len_in, addr_in, beat_done;
  logic addr_sel, addr_ser_out, busy, done;

  logic [7:0] exp_frames[$];
  bit         exp_done[$];
  int         checks   = 0;
  int         failures = 0;
  bit         trunc_ok = 1'b0;

  burst_addr_sequencer #(
    .ADDR_W(8),
    .LEN_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .burst_en     (burst_en),
    .mode_sel     (mode_sel),
    .start        (start),
    .burst_len_in (burst_len_in),
    .addr_in      (addr_in),
    .beat_done    (beat_done),
    .addr_sel     (addr_sel),
    .addr_ser_out (addr_ser_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command yields beats = (burst ? len+1 : 1) frames of addr+b mod 256.
  task automatic push_model(input bit mode, input logic [3:0] len, input logic [7:0] addr);
    int beats;
    beats = mode ? int'(len) + 1 : 1;
    for (int b = 0; b < beats; b++) exp_frames.push_back(8'(int'(addr) + b));
    exp_done.push_back(1'b1);
  endtask

  task automatic flush_model();
    exp_frames.delete();
    exp_done.delete();
  endtask

  // Starts a command from IDLE; returns in the first SHIFT cycle.
  task automatic issue(input bit mode, input logic [3:0] len, input logic [7:0] addr, input bit inject);
    start    = 1'b1;
    mode_sel = mode;
    step();
    start    = 1'b0;
    mode_sel = 1'($urandom);
    push_model(mode, len, addr);
    for (int i = 0; i < 8; i++) begin
      addr_in      = addr[7-i];
      burst_len_in = (i < 4) ? len[3-i] : 1'($urandom);
      start        = (inject && i == 2);
      if (i == 7) chk("load_sel_low", {31'd0, addr_sel}, 32'd0);
      step();
    end
    start        = 1'b0;
    addr_in      = 1'($urandom);
    burst_len_in = 1'($urandom);
    chk("sel_rise", {31'd0, addr_sel}, 32'd1);
  endtask

  task automatic wait_frame_end(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (addr_sel !== 1'b1 && n < 200) begin step(); n++; end
    while (addr_sel === 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin
      failures++;
      ok = 1'b0;
      $display("FAIL frame_timeout: got no frame end within %0d cycles, expected one", n);
    end
  endtask

  task automatic serve(input int beats, input int gap, input bit rand_gap);
    bit ok;
    int n;
    for (int b = 0; b < beats; b++) begin
      wait_frame_end(ok);
      if (!ok) return;
      repeat (rand_gap ? $urandom_range(0, 4) : gap) step();
      beat_done = 1'b1;
      step();
      beat_done = 1'b0;
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin step(); n++; end
    chk("idle_after_burst", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: assembles frames while addr_sel is high and scores them and done pulses.
  initial begin
    logic [7:0] frame;
    logic [7:0] e;
    int nbits;
    nbits = 0;
    frame = '0;
    forever begin
      @(negedge clk);
      if (addr_sel === 1'b1) begin
        frame = {frame[6:0], addr_ser_out};
        nbits++;
        if (nbits == 8) begin
          checks++;
          if (exp_frames.size() == 0) begin
            failures++;
            $display("FAIL extra_frame: got frame %02h, expected none", frame);
          end else begin
            e = exp_frames.pop_front();
            if (frame !== e) begin
              failures++;
              $display("FAIL frame: got %02h expected %02h at %0t", frame, e, $time);
            end
          end
          nbits = 0;
        end
      end else begin
        if (nbits != 0 && !trunc_ok) begin
          checks++;
          failures++;
          $display("FAIL short_frame: got %0d bits expected 8", nbits);
        end
        nbits = 0;
        checks++;
        if (addr_ser_out !== 1'b0) begin
          failures++;
          $display("FAIL ser_idle: got %b expected 0 at %0t", addr_ser_out, $time);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
        end else begin
          void'(exp_done.pop_front());
          if (exp_frames.size() != 0) begin
            failures++;
            $display("FAIL done_early: got done with %0d frames pending, expected 0", exp_frames.size());
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [3:0] l;
    bit m;
    rst = 1'b0; burst_en = 1'b1; mode_sel = 1'b0; start = 1'b0;
    burst_len_in = 1'b0; addr_in = 1'b0; beat_done = 1'b0;
    #3;
    chk("rst_addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("rst_ser", {31'd0, addr_ser_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // 1: single mode, length field ignored
    issue(1'b0, 4'b0011, 8'hA5, 1'b0);
    begin
      bit ok;
      wait_frame_end(ok);
      beat_done = 1'b1;
      step();
      beat_done = 1'b0;
      chk("t1_done", {30'd0, done, busy}, 32'd3);
      step();
      chk("t1_busy_fall", {30'd0, done, busy}, 32'd0);
    end
    step();

    // 2: burst wrap FE, FF, 00
    issue(1'b1, 4'b0010, 8'hFE, 1'b0);
    serve(3, 3, 1'b0);

    // 3: abort in 4th SHIFT cycle of the first beat, then a fresh command
    issue(1'b1, 4'd5, 8'($urandom), 1'b0);
    step(); step(); step();
    burst_en = 1'b0;
    trunc_ok = 1'b1;
    step();
    chk("abort_state", {29'd0, addr_sel, busy, done}, 32'd0);
    flush_model();
    burst_en = 1'b1;
    step(); step();
    trunc_ok = 1'b0;
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    a = 8'($urandom);
    issue(1'b1, 4'd1, a, 1'b0);
    serve(2, 0, 1'b1);

    // 4: ignored start in LOAD/SHIFT and beat_done in SHIFT
    issue(1'b1, 4'd1, 8'($urandom), 1'b1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat_done = 1'b1;
    step();
    beat_done = 1'b0;
    chk("t4_still_shift", {31'd0, addr_sel}, 32'd1);
    serve(2, 1, 1'b0);

    // 5: asynchronous reset while waiting for beat_done
    issue(1'b1, 4'd3, 8'($urandom), 1'b0);
    begin
      bit ok;
      wait_frame_end(ok);
    end
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_outputs", {28'd0, addr_sel, addr_ser_out, busy, done}, 32'd0);
    flush_model();
    step();
    rst = 1'b1;
    step();
    chk("arst_idle", {31'd0, busy}, 32'd0);
    issue(1'b1, 4'd2, 8'h7E, 1'b0);
    serve(3, 0, 1'b1);

    // 6: maximum length
    issue(1'b1, 4'hF, 8'h00, 1'b0);
    serve(16, 0, 1'b1);

    // random commands
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom);
      l = 4'($urandom);
      a = 8'($urandom);
      issue(m, l, a, 1'b0);
      serve(m ? int'(l) + 1 : 1, 0, 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    chk("drain_frames", exp_frames.size(), 32'd0);
    chk("drain_done", exp_done.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
